// File: rtl/vga_sync_decoder.sv
// Receive-side VGA timing decoder: rebuilds col/row from HSYNC/VSYNC edges,
// checks line/frame timing against the raster parameters, reports lock and errors.
module vga_sync_decoder #(
    parameter int unsigned H_VISIBLE       = 640,
    parameter int unsigned H_FRONT         = 16,
    parameter int unsigned H_SYNC          = 96,
    parameter int unsigned H_BACK          = 48,
    parameter int unsigned V_VISIBLE       = 480,
    parameter int unsigned V_FRONT         = 10,
    parameter int unsigned V_SYNC          = 2,
    parameter int unsigned V_BACK          = 33,
    parameter bit          SYNC_ACTIVE_LOW = 1'b1,
    parameter int unsigned LOCK_FRAMES     = 2
) (
    input  logic       clk,
    input  logic       rst_n,
    input  logic       hsync,
    input  logic       vsync,
    input  logic [5:0] rgb,
    output logic [9:0] col,
    output logic [9:0] row,
    output logic       visible,
    output logic [5:0] rgb_out,
    output logic       frame_start,
    output logic       locked,
    output logic       err
);
    localparam int unsigned CW       = 10;
    localparam int unsigned RGB_W    = 6;
    localparam int unsigned H_TOTAL  = H_VISIBLE + H_FRONT + H_SYNC + H_BACK;
    localparam int unsigned V_TOTAL  = V_VISIBLE + V_FRONT + V_SYNC + V_BACK;
    localparam int unsigned H_LOAD   = H_VISIBLE + H_FRONT;
    localparam int unsigned H_TRAIL  = H_LOAD + H_SYNC;
    localparam int unsigned V_LOAD   = V_VISIBLE + V_FRONT;
    localparam int unsigned V_TRAIL  = V_LOAD + V_SYNC;
    localparam int unsigned TO_LIMIT = 2 * H_TOTAL;
    localparam int unsigned TO_W     = $clog2(TO_LIMIT + 1);
    localparam int unsigned FC_W     = $clog2(LOCK_FRAMES + 1);

    typedef enum logic [1:0] {SEARCH, HLOCK, VTRACK, LOCKED} state_e;

    state_e             state_q, state_d;
    logic               hs_q, hs_d, vs_q, vs_d, hs_qq, vs_qq;
    logic [RGB_W-1:0]   rgb_q, rgb_d;
    logic [CW-1:0]      col_q, col_d, row_q, row_d;
    logic [TO_W-1:0]    to_cnt_q, to_cnt_d;
    logic [FC_W-1:0]    frame_cnt_q, frame_cnt_d;
    logic               visible_q, visible_d, frame_start_q, frame_start_d;
    logic               locked_q, locked_d, err_q, err_d;
    logic [RGB_W-1:0]   rgb_out_q, rgb_out_d;

    logic               hs_lead, hs_trail, vs_lead, vs_trail, col_wrap;
    logic               h_viol, v_viol, violation;
    logic [CW-1:0]      col_inc, row_inc;
    logic [FC_W-1:0]    frame_cnt_inc;

    always_comb begin
        hs_d          = SYNC_ACTIVE_LOW ? ~hsync : hsync;
        vs_d          = SYNC_ACTIVE_LOW ? ~vsync : vsync;
        rgb_d         = rgb;
        state_d       = state_q;
        frame_cnt_d   = frame_cnt_q;
        err_d         = 1'b0;

        hs_lead  = hs_q & ~hs_qq;
        hs_trail = ~hs_q & hs_qq;
        vs_lead  = vs_q & ~vs_qq;
        vs_trail = ~vs_q & vs_qq;

        col_inc  = (col_q == CW'(H_TOTAL - 1)) ? '0 : col_q + CW'(1);
        col_wrap = !hs_lead && (col_q == CW'(H_TOTAL - 1));
        col_d    = hs_lead ? CW'(H_LOAD) : col_inc;
        row_inc  = (row_q == CW'(V_TOTAL - 1)) ? '0 : row_q + CW'(1);
        row_d    = vs_lead ? CW'(V_LOAD) : (col_wrap ? row_inc : row_q);

        // Timeout counter saturates so the missing-hsync error fires only once
        if (hs_lead)
            to_cnt_d = '0;
        else if (to_cnt_q == TO_W'(TO_LIMIT))
            to_cnt_d = to_cnt_q;
        else
            to_cnt_d = to_cnt_q + TO_W'(1);

        h_viol = (hs_lead && (col_q != CW'(H_LOAD - 1)))
              || (hs_trail && (col_d != CW'(H_TRAIL)))
              || (!hs_lead && (to_cnt_q == TO_W'(TO_LIMIT - 1)));
        v_viol = (vs_lead && (row_q != CW'(V_LOAD - 1)))
              || (vs_trail && (row_d != CW'(V_TRAIL)));

        // Row is not aligned until the first vsync edge, so vsync is judged only after it
        violation = (state_q != SEARCH)
                 && (h_viol || (((state_q == VTRACK) || (state_q == LOCKED)) && v_viol));

        frame_cnt_inc = frame_cnt_q + FC_W'(1);

        if (violation) begin
            err_d       = 1'b1;
            frame_cnt_d = '0;
            state_d     = hs_lead ? HLOCK : SEARCH;
        end else begin
            case (state_q)
                SEARCH: if (hs_lead) state_d = HLOCK;
                HLOCK: begin
                    if (vs_lead) begin
                        state_d     = VTRACK;
                        frame_cnt_d = '0;
                    end
                end
                VTRACK: begin
                    if (vs_lead) begin
                        frame_cnt_d = frame_cnt_inc;
                        if (frame_cnt_inc == FC_W'(LOCK_FRAMES)) state_d = LOCKED;
                    end
                end
                LOCKED:  state_d = LOCKED;
                default: state_d = SEARCH;
            endcase
        end

        locked_d      = (state_q == LOCKED);
        visible_d     = locked_d && (col_d < CW'(H_VISIBLE)) && (row_d < CW'(V_VISIBLE));
        rgb_out_d     = visible_d ? rgb_q : '0;
        frame_start_d = locked_d && (col_d == '0) && (row_d == '0);
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q       <= SEARCH;
            hs_q          <= 1'b0;
            vs_q          <= 1'b0;
            hs_qq         <= 1'b0;
            vs_qq         <= 1'b0;
            rgb_q         <= '0;
            col_q         <= '0;
            row_q         <= '0;
            to_cnt_q      <= '0;
            frame_cnt_q   <= '0;
            visible_q     <= 1'b0;
            rgb_out_q     <= '0;
            frame_start_q <= 1'b0;
            locked_q      <= 1'b0;
            err_q         <= 1'b0;
        end else begin
            state_q       <= state_d;
            hs_q          <= hs_d;
            vs_q          <= vs_d;
            hs_qq         <= hs_q;
            vs_qq         <= vs_q;
            rgb_q         <= rgb_d;
            col_q         <= col_d;
            row_q         <= row_d;
            to_cnt_q      <= to_cnt_d;
            frame_cnt_q   <= frame_cnt_d;
            visible_q     <= visible_d;
            rgb_out_q     <= rgb_out_d;
            frame_start_q <= frame_start_d;
            locked_q      <= locked_d;
            err_q         <= err_d;
        end
    end

    assign col         = col_q;
    assign row         = row_q;
    assign visible     = visible_q;
    assign rgb_out     = rgb_out_q;
    assign frame_start = frame_start_q;
    assign locked      = locked_q;
    assign err         = err_q;

endmodule

// File: tb/tb_vga_sync_decoder.sv
// Scoreboard bench for vga_sync_decoder on a reduced raster (32x20 totals):
// a stream model pushes expected samples, a monitor pops and compares them.
module tb_vga_sync_decoder;
    localparam int HV = 16, HF = 4, HS = 6, HB = 6;
    localparam int VV = 12, VF = 2, VS = 2, VB = 4;
    localparam int HT = HV + HF + HS + HB;
    localparam int VT = VV + VF + VS + VB;
    localparam int LOCK_FRAMES = 2;
    localparam int FRAME = HT * VT;

    typedef struct {
        int col;
        int row;
        bit vs_lead;
        bit exp_err;
    } rec_t;

    logic       clk = 1'b0;
    logic       rst_n = 1'b0;
    logic       hsync, vsync;
    logic [5:0] rgb;
    logic [9:0] col, row;
    logic       visible, frame_start, locked, err;
    logic [5:0] rgb_out;

    int n_vec = 0;
    int n_fail = 0;

    vga_sync_decoder #(
        .H_VISIBLE(HV), .H_FRONT(HF), .H_SYNC(HS), .H_BACK(HB),
        .V_VISIBLE(VV), .V_FRONT(VF), .V_SYNC(VS), .V_BACK(VB),
        .SYNC_ACTIVE_LOW(1'b1), .LOCK_FRAMES(LOCK_FRAMES)
    ) dut (
        .clk(clk), .rst_n(rst_n), .hsync(hsync), .vsync(vsync), .rgb(rgb),
        .col(col), .row(row), .visible(visible), .rgb_out(rgb_out),
        .frame_start(frame_start), .locked(locked), .err(err)
    );

    always #5 clk = ~clk;

    function automatic void check(input string name, input int act, input int exp);
        n_vec++;
        if (act != exp) begin
            n_fail++;
            $display("FAIL %s: got %0d, expected %0d (t=%0t)", name, act, exp, $time);
        end
    endfunction

    rec_t q[$];

    // Stream model state and fault-injection requests
    int mcol = 0, mrow = 0, since_lead = 0, gate_lines = 0;
    bit prev_hs = 1'b0, prev_vs = 1'b0, hs_act, vs_act, hs_lead, vs_lead;
    bit hs_gate = 1'b0, gate_req = 1'b0;
    bit stretch_req = 1'b0, stretch_armed = 1'b0;
    bit short_req = 1'b0, short_armed = 1'b0;
    rec_t dr;

    initial begin
        hsync = 1'b1;
        vsync = 1'b1;
        rgb   = '0;
        forever begin
            @(posedge clk);
            #1;
            hs_act = !hs_gate && (mcol >= HV + HF) && (mcol < HV + HF + HS);
            vs_act = (mrow >= VV + VF) && (mrow < VV + VF + VS);
            hsync  = !hs_act;
            vsync  = !vs_act;
            rgb    = 6'(mcol);
            hs_lead = hs_act && !prev_hs;
            vs_lead = vs_act && !prev_vs;
            prev_hs = hs_act;
            prev_vs = vs_act;
            since_lead = hs_lead ? 0 : since_lead + 1;
            dr.col = mcol;
            dr.row = mrow;
            dr.vs_lead = vs_lead;
            dr.exp_err = (since_lead == 2 * HT);
            if (stretch_armed && hs_lead) begin
                dr.exp_err = 1'b1;
                stretch_armed = 1'b0;
            end
            if (short_armed && vs_lead) begin
                dr.exp_err = 1'b1;
                short_armed = 1'b0;
            end
            q.push_back(dr);
            // Advance raster; a stretched line repeats the last front-porch column
            if (stretch_req && mcol == HV + HF - 1) begin
                stretch_req = 1'b0;
                stretch_armed = 1'b1;
            end else if (mcol == HT - 1) begin
                mcol = 0;
                if (hs_gate) begin
                    gate_lines--;
                    if (gate_lines == 0) hs_gate = 1'b0;
                end
                if (gate_req) begin
                    gate_req = 1'b0;
                    hs_gate = 1'b1;
                    gate_lines = 3;
                end
                if (short_req && mrow == VV + VF - 2) begin
                    short_req = 1'b0;
                    short_armed = 1'b1;
                    mrow = VV + VF;
                end else begin
                    mrow = (mrow == VT - 1) ? 0 : mrow + 1;
                end
            end else begin
                mcol++;
            end
        end
    end

    rec_t mr;
    int lock_cnt = 0;
    bit exp_locked, exp_vis, exp_fs;
    bit prev_locked = 1'b0, prev_exp = 1'b0;

    // Monitor: outputs at a negedge belong to the sample pushed two cycles earlier
    initial begin
        forever begin
            @(negedge clk);
            if (q.size() >= 3) begin
                mr = q.pop_front();
                exp_locked = 1'b0;
                if (!rst_n) begin
                    check("reset_outputs",
                          int'({col, row, visible, rgb_out, frame_start, locked, err}), 0);
                    lock_cnt = 0;
                end else begin
                    exp_locked = (lock_cnt >= LOCK_FRAMES + 1);
                    exp_vis = exp_locked && (mr.col < HV) && (mr.row < VV);
                    exp_fs  = exp_locked && (mr.col == 0) && (mr.row == 0);
                    check("visible", int'(visible), int'(exp_vis));
                    if (visible) begin
                        check("col", int'(col), mr.col);
                        check("row", int'(row), mr.row);
                        check("rgb_out", int'(rgb_out), mr.col % 64);
                    end else begin
                        check("rgb_blank", int'(rgb_out), 0);
                    end
                    if (locked != prev_locked || exp_locked != prev_exp)
                        check("locked", int'(locked), int'(exp_locked));
                    if (err || mr.exp_err)
                        check("err", int'(err), int'(mr.exp_err));
                    if (frame_start || exp_fs)
                        check("frame_start", int'(frame_start), int'(exp_fs));
                    if (mr.exp_err)
                        lock_cnt = 0;
                    else if (mr.vs_lead && lock_cnt < LOCK_FRAMES + 1)
                        lock_cnt++;
                end
                prev_locked = locked;
                prev_exp = exp_locked;
            end
        end
    end

    task automatic run(input int n);
        repeat (n) @(posedge clk);
        #2;
    endtask

    task automatic wait_locked(input int budget, input string name);
        int n = 0;
        while (locked !== 1'b1 && n < budget) begin
            run(1);
            n++;
        end
        check(name, int'(locked), 1);
    endtask

    task automatic wait_pos(input int r, input int c);
        int n = 0;
        while (!(mrow == r && mcol == c) && n < 2 * FRAME) begin
            run(1);
            n++;
        end
        check("wait_raster_pos", int'(mrow == r && mcol == c), 1);
    endtask

    initial begin
        run(4);
        rst_n = 1'b1;
        wait_locked(6 * FRAME, "lock_from_reset");
        run(2 * FRAME);

        // Reset inside the visible area, with both syncs inactive
        wait_pos(3, 2);
        rst_n = 1'b0;
        run(3);
        rst_n = 1'b1;
        wait_locked(6 * FRAME, "relock_after_reset");
        run(FRAME);

        stretch_req = 1'b1;
        run(FRAME);
        wait_locked(6 * FRAME, "relock_after_long_line");
        run(FRAME);

        wait_pos(1, 0);
        gate_req = 1'b1;
        run(FRAME);
        wait_locked(6 * FRAME, "relock_after_timeout");
        run(FRAME);

        short_req = 1'b1;
        run(2 * FRAME);
        wait_locked(6 * FRAME, "relock_after_short_frame");
        run(2 * FRAME);

        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_fail);
        $finish;
    end

endmodule

// File: doc/vga_sync_decoder.md
Name: vga_sync_decoder

Overview:
- Receive-side counterpart of the VGA timing generator: consumes a HSYNC/VSYNC/6-bit RGB stream (640x480@60, 800x525 totals) and recovers col, row and visible from the sync edges.
- Used as an on-chip loopback monitor and as the bench checker for the display pipeline.
- Checks line and frame timing against the parameters, reports lock, and flags errors.

Parameters:
- H_VISIBLE, 640, active pixels per line
- H_FRONT, 16, horizontal front porch
- H_SYNC, 96, hsync pulse width
- H_BACK, 48, horizontal back porch (H_TOTAL = sum = 800)
- V_VISIBLE, 480, active lines
- V_FRONT, 10, vertical front porch
- V_SYNC, 2, vsync pulse width in lines
- V_BACK, 33, vertical back porch (V_TOTAL = 525)
- SYNC_ACTIVE_LOW, 1, 1 = sync pulses are low
- LOCK_FRAMES, 2, error-free frames required before lock

Ports:
- clk  in  1  pixel clock, 25.1 MHz PLL clock
- rst_n  in  1  asynchronous active-low reset
- hsync  in  1  horizontal sync
- vsync  in  1  vertical sync
- rgb  in  6  pixel data
- col  out  10  recovered column
- row  out  10  recovered row
- visible  out  1  locked and col<H_VISIBLE and row<V_VISIBLE
- rgb_out  out  6  rgb sample when visible, else 0
- frame_start  out  1  1-cycle pulse at col=0,row=0 while locked
- locked  out  1  timing locked
- err  out  1  1-cycle pulse on any timing violation

Behaviour:
- Reset: all outputs 0, all counters 0, state SEARCH.
- Input stage: hsync, vsync and rgb are registered once into *_q. Sync is normalised to active-high using SYNC_ACTIVE_LOW.
- Edge detection compares *_q with a second register.
- Output latency: 2 cycles from input pins to col/row/visible/rgb_out/frame_start.
- The sample on which HSYNC first goes active appears on the outputs with col=656 (H_VISIBLE+H_FRONT), 2 clocks later.
- Column counter:
  - On an hsync leading edge, load H_VISIBLE+H_FRONT.
  - Otherwise increment, wrapping H_TOTAL-1 -> 0.
- Row counter:
  - Increments on the col wrap to 0, wrapping V_TOTAL-1 -> 0.
  - A vsync leading edge (aligned to col=0) loads V_VISIBLE+V_FRONT.
- States:
  - SEARCH: col/row outputs free-run, visible=0. The first hsync leading edge loads col and enters HLOCK.
  - HLOCK: lines tracked, waiting for a vsync leading edge. The edge loads row and enters VTRACK with frame_cnt=0.
  - VTRACK: each further error-free vsync leading edge increments frame_cnt. When frame_cnt reaches LOCK_FRAMES, enter LOCKED; locked=1 from the next cycle.
  - LOCKED: steady state. locked=1, visible/rgb_out/frame_start active.
- Violations (checked in HLOCK, VTRACK, LOCKED). Each one pulses err for 1 cycle, returns to SEARCH, clears frame_cnt and drops locked the next cycle:
  - hsync leading edge while the counter (pre-load) is not H_VISIBLE+H_FRONT-1.
  - hsync trailing edge at a col other than H_VISIBLE+H_FRONT+H_SYNC.
  - vsync leading edge at a row other than V_VISIBLE+V_FRONT-1 (pre-load), or vsync pulse length other than V_SYNC lines.
  - No hsync leading edge for 2*H_TOTAL cycles (timeout counter, cleared on each edge).
- On a violation that is an hsync leading edge, col is still reloaded in that cycle and the decoder moves directly to HLOCK.
- Simultaneous hsync and vsync leading edges: the hsync check and the vsync check are both evaluated; either failing is a violation, and a single err pulse is produced.
- rgb_out is 0 whenever visible=0. frame_start never fires unless LOCKED.
- Reset mid-frame: immediate return to reset values; relock requires the full SEARCH->LOCKED sequence.

Test Plan:
- Assert rst_n=0 mid-stream for 3 cycles -> all outputs 0 during reset; after release locked stays 0 until the full lock sequence is seen again.
- Ideal 640x480 stream from the timing-generator model, from reset -> locked rises 1 cycle after the 3rd vsync leading edge (first edge enters VTRACK, 2 more to lock). err never pulses; frame_start pulses once per 420000 cycles.
- Locked, rgb driven = col[5:0] by the model -> whenever visible=1, rgb_out == col_out[5:0] and row_out matches the model row. rgb_out == 0 at col 640..799 and rows 480..524.
- Locked, one line stretched to 801 clocks -> err 1-cycle pulse at the late hsync edge, locked=0 next cycle, relock after 3 further vsync edges.
- Locked, hsync held inactive -> err pulse exactly 1600 cycles after the last hsync leading edge, state SEARCH, visible=0.
- Locked, one frame of 524 lines -> err pulse at that vsync leading edge, locked drops, then relocks.
